keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_map.sv | 16 +
 rtl/keypad_emulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM state encoding, idle row pattern and the
// code-to-matrix-position map used by the emulator and by scanner-side code.
package keypad_pkg;

    localparam int CNT_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESS  = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam logic [5:0] IDLE_ROW = 6'b111111;

    typedef struct packed {
        logic [5:0] row;
        logic [3:0] col;
    } key_pos_t;

    // Both row and column are active-low one-hot positions in the matrix.
    function automatic key_pos_t code_to_pos(input logic [3:0] c);
        case (c)
            4'h0: code_to_pos = '{6'b111110, 4'b1011};
            4'h1: code_to_pos = '{6'b011111, 4'b0111};
            4'h2: code_to_pos = '{6'b011111, 4'b1011};
            4'h3: code_to_pos = '{6'b011111, 4'b1101};
            4'h4: code_to_pos = '{6'b101111, 4'b0111};
            4'h5: code_to_pos = '{6'b101111, 4'b1011};
            4'h6: code_to_pos = '{6'b101111, 4'b1101};
            4'h7: code_to_pos = '{6'b110111, 4'b0111};
            4'h8: code_to_pos = '{6'b110111, 4'b1011};
            4'h9: code_to_pos = '{6'b110111, 4'b1101};
            4'hA: code_to_pos = '{6'b110111, 4'b1110};
            4'hB: code_to_pos = '{6'b111101, 4'b1101};
            4'hC: code_to_pos = '{6'b111011, 4'b1101};
            4'hD: code_to_pos = '{6'b111011, 4'b1011};
            4'hE: code_to_pos = '{6'b111011, 4'b0111};
            4'hF: code_to_pos = '{6'b011111, 4'b1110};
        endcase
    endfunction

endpackage

// File: rtl/keypad_map.sv
// Combinational lookup from key code to its active-low row and column.
module keypad_map
    import keypad_pkg::*;
(
    input  logic [3:0] code,
    output logic [5:0] row,
    output logic [3:0] col
);

    key_pos_t pos;

    assign pos = code_to_pos(code);
    assign row = pos.row;
    assign col = pos.col;

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key of a row/column matrix: on req it closes the contact for a
// held period (optionally preceded by bounce), then releases and pulses done.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 8,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_out,
    output logic [5:0] key_in,
    input  logic       req,
    input  logic [3:0] code,
    input  logic       cancel,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    // The counter runs down, so "even elapsed cycle" means the count parity
    // matches the parity of the loaded value.
    localparam logic             BOUNCE_PAR  = BOUNCE_LOAD[0];

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [3:0]       code_q;
    logic [5:0]       row;
    logic [3:0]       col;
    logic             contact_closed;

    keypad_map u_map (
        .code (code_q),
        .row  (row),
        .col  (col)
    );

    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    if (BOUNCE_CYCLES > 0) begin
                        next_state   = ST_BOUNCE;
                        cnt_load_val = BOUNCE_LOAD;
                    end else begin
                        next_state   = ST_PRESS;
                        cnt_load_val = HOLD_LOAD;
                    end
                end
            end
            ST_BOUNCE: begin
                if (cancel) begin
                    next_state   = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end else if (cnt == '0) begin
                    next_state   = ST_PRESS;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                end
            end
            ST_PRESS: begin
                if (cancel || cnt == '0) begin
                    next_state   = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end
            end
            default: begin
                if (cnt == '0) begin
                    next_state = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
        end else begin
            state <= next_state;
            if (cnt_load) begin
                cnt <= cnt_load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ST_IDLE && req) begin
                code_q <= code;
            end
        end
    end

    assign contact_closed = (state == ST_PRESS) ||
                            (state == ST_BOUNCE && cnt[0] == BOUNCE_PAR);

    // Zero-cycle path from the scanner's column drive, like a real switch.
    assign key_in = (contact_closed && key_out == col) ? row : IDLE_ROW;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_GAP) && (cnt == '0);

endmodule
